// File: rtl/mbc_banked.sv
// rtl/mbc_banked.sv - parametrised cartridge memory-bank controller
//
// Purpose:
//   Decodes CPU bus writes into the RAM-enable, low/high bank and mode
//   registers, forms banked ROM and external-RAM byte addresses from the CPU
//   address, and muxes ROM/RAM read data back onto the CPU bus.
//
// Ports:
//   clock4        in   system clock
//   resetn        in   asynchronous active-low reset
//   address       in   CPU address
//   indata        in   CPU write data
//   outdata       out  CPU read data (0xFF for addresses not owned)
//   load          in   CPU read strobe
//   store         in   CPU write strobe, may be held several cycles
//   rom_address   out  banked ROM byte address
//   rom_data      in   ROM read data
//   rom_load      out  ROM read strobe
//   ram_address   out  banked RAM byte address
//   ram_data_in   in   RAM read data
//   ram_data_out  out  RAM write data (= indata)
//   ram_load      out  RAM read strobe
//   ram_store     out  RAM write strobe
module mbc_banked #(
   parameter int LO_BITS   = 5,
   parameter int HI_BITS   = 2,
   parameter int ROM_BANKS = 128,
   parameter int RAM_BANKS = 4
) (
   input  logic                        clock4,
   input  logic                        resetn,
   input  logic [15:0]                 address,
   input  logic [7:0]                  indata,
   output logic [7:0]                  outdata,
   input  logic                        load,
   input  logic                        store,
   output logic [LO_BITS+HI_BITS+13:0] rom_address,
   input  logic [7:0]                  rom_data,
   output logic                        rom_load,
   output logic [HI_BITS+12:0]         ram_address,
   input  logic [7:0]                  ram_data_in,
   output logic [7:0]                  ram_data_out,
   output logic                        ram_load,
   output logic                        ram_store
);

   localparam int BB = LO_BITS + HI_BITS;
   localparam logic [BB-1:0]      ROM_MASK = BB'(ROM_BANKS - 1);
   // With zero or one RAM bank the bank field is forced to zero.
   localparam logic [HI_BITS-1:0] RAM_MASK = (RAM_BANKS > 1) ? HI_BITS'(RAM_BANKS - 1) : '0;
   localparam logic               HAS_RAM  = (RAM_BANKS != 0);

   logic                r_ram_enable;
   logic [LO_BITS-1:0]  r_bank_lo;
   logic [HI_BITS-1:0]  r_bank_hi;
   logic                r_mode;
   logic                r_store_q;

   logic                w_commit;
   logic [LO_BITS-1:0]  w_lo_field;
   logic [LO_BITS-1:0]  w_lo_next;
   logic                w_rom_win;
   logic                w_ram_win;
   logic [BB-1:0]       w_bank_low_win;
   logic [BB-1:0]       w_bank;
   logic [HI_BITS-1:0]  w_rbank;
   logic                w_ram_hit;

   // Commit only on the rising edge of store so a held strobe writes once.
   // r_store_q resets high: a store already asserted at reset release is
   // ignored until it drops.
   assign w_commit   = store && !r_store_q;

   // Bank 0 cannot be selected through the low register; the remap is applied
   // to the raw field before any ROM-size masking.
   assign w_lo_field = indata[LO_BITS-1:0];
   assign w_lo_next  = (w_lo_field == '0) ? LO_BITS'(1) : w_lo_field;

   always_ff @(posedge clock4 or negedge resetn) begin
      if (!resetn) begin
         r_ram_enable <= 1'b0;
         r_bank_lo    <= LO_BITS'(1);
         r_bank_hi    <= '0;
         r_mode       <= 1'b0;
         r_store_q    <= 1'b1;
      end else begin
         r_store_q <= store;
         if (w_commit) begin
            case (address[15:13])
               3'd0:    r_ram_enable <= (indata[3:0] == 4'hA);
               3'd1:    r_bank_lo    <= w_lo_next;
               3'd2:    r_bank_hi    <= indata[HI_BITS-1:0];
               3'd3:    r_mode       <= indata[0];
               default: ;
            endcase
         end
      end
   end

   assign w_rom_win      = !address[15];
   assign w_ram_win      = (address[15:13] == 3'b101);

   // Lower ROM window is bank 0 unless mode routes the high register there.
   assign w_bank_low_win = r_mode ? {r_bank_hi, {LO_BITS{1'b0}}} : '0;
   assign w_bank         = address[14] ? {r_bank_hi, r_bank_lo} : w_bank_low_win;
   assign rom_address    = {w_bank & ROM_MASK, address[13:0]};
   assign rom_load       = load && w_rom_win;

   assign w_rbank        = r_mode ? r_bank_hi : '0;
   assign ram_address    = {w_rbank & RAM_MASK, address[12:0]};
   assign w_ram_hit      = w_ram_win && r_ram_enable && HAS_RAM;
   assign ram_load       = load && w_ram_hit;
   // Level strobe: the backing RAM tolerates repeated identical writes.
   assign ram_store      = store && w_ram_hit;
   assign ram_data_out   = indata;

   assign outdata        = w_rom_win ? rom_data : (w_ram_hit ? ram_data_in : 8'hFF);

endmodule
